scr1_ialu_issue_buf: RTL and testbench

//  Command buffer and issue sequencer sitting directly upstream of the IALU.

---
 rtl/scr1_ialu_issue_pkg.sv | 34 +++
 rtl/scr1_ialu_issue_fifo.sv | 82 ++++++++
 rtl/scr1_ialu_issue_buf.sv | 135 +++++++++++++
 tb/tb_scr1_ialu_issue_buf.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_ialu_issue_pkg.sv
// Shared types for the IALU issue buffer: command encoding, issue FSM states and queue entry layout.
package scr1_ialu_issue_pkg;

    localparam int unsigned SCR1_IALU_ISSUE_XLEN          = 32;
    localparam int unsigned SCR1_IALU_ISSUE_DEPTH_DEFAULT = 4;
    localparam int unsigned SCR1_IALU_ISSUE_TAG_W_DEFAULT = 5;

    typedef enum logic [3:0] {
        SCR1_IALU_CMD_NONE   = 4'd0,
        SCR1_IALU_CMD_ADD    = 4'd1,
        SCR1_IALU_CMD_SUB    = 4'd2,
        SCR1_IALU_CMD_AND    = 4'd3,
        SCR1_IALU_CMD_OR     = 4'd4,
        SCR1_IALU_CMD_XOR    = 4'd5,
        SCR1_IALU_CMD_SUB_LT = 4'd6,
        SCR1_IALU_CMD_SUB_EQ = 4'd7,
        SCR1_IALU_CMD_MUL    = 4'd8,
        SCR1_IALU_CMD_DIV    = 4'd9
    } type_scr1_ialu_cmd_sel_e;

    typedef enum logic [1:0] {
        SCR1_IALU_ISSUE_IDLE  = 2'd0,
        SCR1_IALU_ISSUE_ISSUE = 2'd1,
        SCR1_IALU_ISSUE_RESP  = 2'd2
    } type_scr1_ialu_issue_fsm_e;

    typedef struct packed {
        logic [SCR1_IALU_ISSUE_XLEN-1:0]          op1;
        logic [SCR1_IALU_ISSUE_XLEN-1:0]          op2;
        type_scr1_ialu_cmd_sel_e                  cmd;
        logic [SCR1_IALU_ISSUE_TAG_W_DEFAULT-1:0] tag;
    } type_scr1_ialu_issue_entry_s;

endpackage

// File: rtl/scr1_ialu_issue_fifo.sv
// Generic synchronous FIFO; head is the oldest entry, clr empties it in one cycle.
module scr1_ialu_issue_fifo
    import scr1_ialu_issue_pkg::*;
#(
    parameter int unsigned DEPTH   = SCR1_IALU_ISSUE_DEPTH_DEFAULT,
    parameter type         entry_t = type_scr1_ialu_issue_entry_s
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   push,
    input  logic   pop,
    input  entry_t wr_data,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    entry_t           mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == {CNT_W{1'b0}});
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CNT_W'(1'b1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1'b1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_ok && !clr) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/scr1_ialu_issue_buf.sv
// IALU issue buffer: queues requests, presents one op at a time to the IALU and holds its result
// in a response register until the consumer takes it.
module scr1_ialu_issue_buf
    import scr1_ialu_issue_pkg::*;
#(
    parameter int unsigned DEPTH = SCR1_IALU_ISSUE_DEPTH_DEFAULT,
    parameter int unsigned TAG_W = SCR1_IALU_ISSUE_TAG_W_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            req_vd,
    output logic                            req_rdy,
    input  logic [SCR1_IALU_ISSUE_XLEN-1:0] req_op1,
    input  logic [SCR1_IALU_ISSUE_XLEN-1:0] req_op2,
    input  type_scr1_ialu_cmd_sel_e         req_cmd,
    input  logic [TAG_W-1:0]                req_tag,
    output logic                            ialu_vd,
    output logic [SCR1_IALU_ISSUE_XLEN-1:0] ialu_op1,
    output logic [SCR1_IALU_ISSUE_XLEN-1:0] ialu_op2,
    output type_scr1_ialu_cmd_sel_e         ialu_cmd,
    input  logic                            ialu_rdy,
    input  logic [SCR1_IALU_ISSUE_XLEN-1:0] ialu_res,
    input  logic                            ialu_cmp,
    output logic                            rsp_vd,
    input  logic                            rsp_rdy,
    output logic [SCR1_IALU_ISSUE_XLEN-1:0] rsp_res,
    output logic                            rsp_cmp,
    output logic [TAG_W-1:0]                rsp_tag
);

    typedef struct packed {
        logic [SCR1_IALU_ISSUE_XLEN-1:0] op1;
        logic [SCR1_IALU_ISSUE_XLEN-1:0] op2;
        type_scr1_ialu_cmd_sel_e         cmd;
        logic [TAG_W-1:0]                tag;
    } entry_t;

    type_scr1_ialu_issue_fsm_e       state_q, state_d;
    logic [SCR1_IALU_ISSUE_XLEN-1:0] rsp_res_q, rsp_res_d;
    logic                            rsp_cmp_q, rsp_cmp_d;
    logic [TAG_W-1:0]                rsp_tag_q, rsp_tag_d;
    entry_t                          req_entry;
    entry_t                          fifo_head;
    logic                            fifo_push;
    logic                            fifo_pop;
    logic                            fifo_full;
    logic                            fifo_empty;

    assign req_entry = '{op1: req_op1, op2: req_op2, cmd: req_cmd, tag: req_tag};
    assign fifo_push = req_vd & ~fifo_full & ~flush;
    assign fifo_pop  = (state_q == SCR1_IALU_ISSUE_ISSUE) & ialu_rdy & ~flush;

    scr1_ialu_issue_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (req_entry),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Issue sequencing; a push in the same cycle counts as work so an empty buffer issues next cycle.
    always_comb begin
        state_d   = state_q;
        rsp_res_d = rsp_res_q;
        rsp_cmp_d = rsp_cmp_q;
        rsp_tag_d = rsp_tag_q;
        if (flush) begin
            state_d = SCR1_IALU_ISSUE_IDLE;
        end else begin
            case (state_q)
                SCR1_IALU_ISSUE_IDLE: begin
                    if (!fifo_empty || fifo_push) begin
                        state_d = SCR1_IALU_ISSUE_ISSUE;
                    end else begin
                        state_d = SCR1_IALU_ISSUE_IDLE;
                    end
                end
                SCR1_IALU_ISSUE_ISSUE: begin
                    if (ialu_rdy) begin
                        state_d   = SCR1_IALU_ISSUE_RESP;
                        rsp_res_d = ialu_res;
                        rsp_cmp_d = ialu_cmp;
                        rsp_tag_d = fifo_head.tag;
                    end else begin
                        state_d = SCR1_IALU_ISSUE_ISSUE;
                    end
                end
                SCR1_IALU_ISSUE_RESP: begin
                    if (!rsp_rdy) begin
                        state_d = SCR1_IALU_ISSUE_RESP;
                    end else if (!fifo_empty || fifo_push) begin
                        state_d = SCR1_IALU_ISSUE_ISSUE;
                    end else begin
                        state_d = SCR1_IALU_ISSUE_IDLE;
                    end
                end
                default: state_d = SCR1_IALU_ISSUE_IDLE;
            endcase
        end
    end

    // FSM state and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SCR1_IALU_ISSUE_IDLE;
            rsp_res_q <= {SCR1_IALU_ISSUE_XLEN{1'b0}};
            rsp_cmp_q <= 1'b0;
            rsp_tag_q <= {TAG_W{1'b0}};
        end else begin
            state_q   <= state_d;
            rsp_res_q <= rsp_res_d;
            rsp_cmp_q <= rsp_cmp_d;
            rsp_tag_q <= rsp_tag_d;
        end
    end

    assign req_rdy  = ~fifo_full;
    assign ialu_vd  = (state_q == SCR1_IALU_ISSUE_ISSUE);
    assign ialu_op1 = fifo_head.op1;
    assign ialu_op2 = fifo_head.op2;
    assign ialu_cmd = fifo_head.cmd;
    assign rsp_vd   = (state_q == SCR1_IALU_ISSUE_RESP);
    assign rsp_res  = rsp_res_q;
    assign rsp_cmp  = rsp_cmp_q;
    assign rsp_tag  = rsp_tag_q;

endmodule

// File: tb/tb_scr1_ialu_issue_buf.sv
// Directed and randomized bench for scr1_ialu_issue_buf with an IALU stub and a queue-based reference model.
module tb_scr1_ialu_issue_buf;
    import scr1_ialu_issue_pkg::*;

    localparam int DEPTH = 4;

    logic                    clk;
    logic                    rst;
    logic                    flush;
    logic                    req_vd;
    logic                    req_rdy;
    logic [31:0]             req_op1;
    logic [31:0]             req_op2;
    type_scr1_ialu_cmd_sel_e req_cmd;
    logic [4:0]              req_tag;
    logic                    ialu_vd;
    logic [31:0]             ialu_op1;
    logic [31:0]             ialu_op2;
    type_scr1_ialu_cmd_sel_e ialu_cmd;
    logic                    ialu_rdy;
    logic [31:0]             ialu_res;
    logic                    ialu_cmp;
    logic                    rsp_vd;
    logic                    rsp_rdy;
    logic [31:0]             rsp_res;
    logic                    rsp_cmp;
    logic [4:0]              rsp_tag;

    scr1_ialu_issue_buf #(.DEPTH(DEPTH), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_vd(req_vd), .req_rdy(req_rdy), .req_op1(req_op1), .req_op2(req_op2),
        .req_cmd(req_cmd), .req_tag(req_tag),
        .ialu_vd(ialu_vd), .ialu_op1(ialu_op1), .ialu_op2(ialu_op2), .ialu_cmd(ialu_cmd),
        .ialu_rdy(ialu_rdy), .ialu_res(ialu_res), .ialu_cmp(ialu_cmp),
        .rsp_vd(rsp_vd), .rsp_rdy(rsp_rdy), .rsp_res(rsp_res), .rsp_cmp(rsp_cmp), .rsp_tag(rsp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        cmp;
        logic [4:0]  tag;
    } exp_t;

    exp_t       exp_q[$];
    logic [4:0] rsp_log[$];
    int         model_cnt;
    int         n_chk;
    int         n_fail;
    int         stub_wait;
    int         stub_lat;
    bit         rdy_noise;
    bit         prev_vd, prev_done, prev_rsp_vd, prev_rsp_taken, prev_flush;
    logic [31:0]             prev_op1, prev_op2, prev_res;
    type_scr1_ialu_cmd_sel_e prev_cmd;
    logic                    prev_cmp;
    logic [4:0]              prev_tag;

    function automatic logic [31:0] alu(type_scr1_ialu_cmd_sel_e c, logic [31:0] a, logic [31:0] b);
        case (c)
            SCR1_IALU_CMD_ADD:    return a + b;
            SCR1_IALU_CMD_SUB:    return a - b;
            SCR1_IALU_CMD_AND:    return a & b;
            SCR1_IALU_CMD_OR:     return a | b;
            SCR1_IALU_CMD_XOR:    return a ^ b;
            SCR1_IALU_CMD_SUB_LT: return a - b;
            SCR1_IALU_CMD_SUB_EQ: return a - b;
            SCR1_IALU_CMD_MUL:    return a * b;
            SCR1_IALU_CMD_DIV:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default:              return 32'd0;
        endcase
    endfunction

    function automatic logic cmpf(type_scr1_ialu_cmd_sel_e c, logic [31:0] a, logic [31:0] b);
        case (c)
            SCR1_IALU_CMD_SUB_LT: return $signed(a) < $signed(b);
            SCR1_IALU_CMD_SUB_EQ: return a == b;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic type_scr1_ialu_cmd_sel_e rand_cmd();
        case ($urandom_range(0, 7))
            0:       return SCR1_IALU_CMD_ADD;
            1:       return SCR1_IALU_CMD_SUB;
            2:       return SCR1_IALU_CMD_AND;
            3:       return SCR1_IALU_CMD_OR;
            4:       return SCR1_IALU_CMD_XOR;
            5:       return SCR1_IALU_CMD_SUB_LT;
            6:       return SCR1_IALU_CMD_SUB_EQ;
            default: return SCR1_IALU_CMD_MUL;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic set_req(input logic [4:0] tag, input type_scr1_ialu_cmd_sel_e c,
                           input logic [31:0] a, input logic [31:0] b);
        req_vd  = 1'b1;
        req_tag = tag;
        req_cmd = c;
        req_op1 = a;
        req_op2 = b;
    endtask

    // One clock cycle: drive the IALU stub, check against the model, update the model, advance.
    task automatic cyc();
        bit push_h, pop_h, rsp_h;
        exp_t e;
        if (ialu_vd === 1'b1) begin
            ialu_res = alu(ialu_cmd, ialu_op1, ialu_op2);
            ialu_cmp = cmpf(ialu_cmd, ialu_op1, ialu_op2);
            ialu_rdy = (stub_wait >= stub_lat);
        end else begin
            ialu_res = $urandom;
            ialu_cmp = 1'($urandom);
            ialu_rdy = rdy_noise ? 1'($urandom) : 1'b0;
        end
        if (!rst) begin
            chk("req_rdy", 64'(req_rdy), 64'(model_cnt < DEPTH));
            if (prev_flush) begin
                chk("flush_ialu_vd", 64'(ialu_vd), 64'(0));
                chk("flush_rsp_vd", 64'(rsp_vd), 64'(0));
            end
            if (ialu_vd === 1'b1 && prev_vd && !prev_done) begin
                chk("ialu_op1_stable", 64'(ialu_op1), 64'(prev_op1));
                chk("ialu_op2_stable", 64'(ialu_op2), 64'(prev_op2));
                chk("ialu_cmd_stable", 64'(ialu_cmd), 64'(prev_cmd));
            end
            if (rsp_vd === 1'b1 && prev_rsp_vd && !prev_rsp_taken) begin
                chk("rsp_res_stable", 64'(rsp_res), 64'(prev_res));
                chk("rsp_cmp_stable", 64'(rsp_cmp), 64'(prev_cmp));
                chk("rsp_tag_stable", 64'(rsp_tag), 64'(prev_tag));
            end
        end
        push_h = !rst && !flush && (req_vd === 1'b1) && (req_rdy === 1'b1);
        pop_h  = !rst && !flush && (ialu_vd === 1'b1) && ialu_rdy;
        rsp_h  = !rst && !flush && (rsp_vd === 1'b1) && rsp_rdy;
        if (rsp_h) begin
            chk("rsp_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_res", 64'(rsp_res), 64'(e.res));
                chk("rsp_cmp", 64'(rsp_cmp), 64'(e.cmp));
                chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
            end
            rsp_log.push_back(rsp_tag);
        end
        if (rst || flush) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            if (push_h) begin
                exp_q.push_back('{res: alu(req_cmd, req_op1, req_op2),
                                  cmp: cmpf(req_cmd, req_op1, req_op2), tag: req_tag});
                model_cnt++;
            end
            if (pop_h) begin
                model_cnt--;
            end
        end
        prev_vd        = (ialu_vd === 1'b1);
        prev_done      = ialu_rdy || flush || rst;
        prev_op1       = ialu_op1;
        prev_op2       = ialu_op2;
        prev_cmd       = ialu_cmd;
        prev_rsp_vd    = (rsp_vd === 1'b1);
        prev_rsp_taken = rsp_rdy || flush || rst;
        prev_res       = rsp_res;
        prev_cmp       = rsp_cmp;
        prev_tag       = rsp_tag;
        prev_flush     = flush && !rst;
        @(posedge clk);
        #1;
        stub_wait = ((ialu_vd === 1'b1) && prev_vd && !prev_done) ? stub_wait + 1 : 0;
    endtask

    task automatic drain();
        req_vd   = 1'b0;
        rsp_rdy  = 1'b1;
        stub_lat = 0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            cyc();
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int          n;
        bit          acc;
        logic [31:0] b_op1;
        n_chk = 0; n_fail = 0; model_cnt = 0; stub_wait = 0; stub_lat = 0; rdy_noise = 1'b0;
        prev_vd = 1'b0; prev_done = 1'b0; prev_rsp_vd = 1'b0; prev_rsp_taken = 1'b0; prev_flush = 1'b0;
        rst = 1'b1; flush = 1'b0; req_vd = 1'b0; rsp_rdy = 1'b1;
        req_op1 = 32'd0; req_op2 = 32'd0; req_cmd = SCR1_IALU_CMD_NONE; req_tag = 5'd0;
        ialu_rdy = 1'b0; ialu_res = 32'd0; ialu_cmp = 1'b0;

        // Power-on reset
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_req_rdy", 64'(req_rdy), 64'(1));
        chk("rst_ialu_vd", 64'(ialu_vd), 64'(0));
        chk("rst_rsp_vd", 64'(rsp_vd), 64'(0));
        chk("rst_rsp_res", 64'(rsp_res), 64'(0));
        chk("rst_rsp_cmp", 64'(rsp_cmp), 64'(0));
        chk("rst_rsp_tag", 64'(rsp_tag), 64'(0));

        // Single ADD, stub ready in the issue cycle
        set_req(5'd3, SCR1_IALU_CMD_ADD, 32'd5, 32'd7);
        cyc();
        req_vd = 1'b0;
        chk("add_ialu_vd", 64'(ialu_vd), 64'(1));
        chk("add_ialu_op1", 64'(ialu_op1), 64'(5));
        chk("add_ialu_op2", 64'(ialu_op2), 64'(7));
        chk("add_ialu_cmd", 64'(ialu_cmd), 64'(SCR1_IALU_CMD_ADD));
        chk("add_rsp_vd_early", 64'(rsp_vd), 64'(0));
        cyc();
        chk("add_rsp_vd", 64'(rsp_vd), 64'(1));
        chk("add_rsp_res", 64'(rsp_res), 64'(12));
        chk("add_rsp_tag", 64'(rsp_tag), 64'(3));
        chk("add_ialu_vd_off", 64'(ialu_vd), 64'(0));
        cyc();
        chk("add_rsp_vd_off", 64'(rsp_vd), 64'(0));

        // Reset in the middle of an issue
        stub_lat = 1000;
        set_req(5'd1, SCR1_IALU_CMD_SUB, 32'd9, 32'd4);
        cyc();
        req_vd = 1'b0;
        cyc();
        chk("midrst_ialu_vd_before", 64'(ialu_vd), 64'(1));
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        chk("midrst_ialu_vd", 64'(ialu_vd), 64'(0));
        chk("midrst_rsp_vd", 64'(rsp_vd), 64'(0));
        chk("midrst_req_rdy", 64'(req_rdy), 64'(1));
        chk("midrst_rsp_tag", 64'(rsp_tag), 64'(0));

        // Fill the buffer while the IALU stalls
        rsp_log.delete();
        for (int t = 0; t < 4; t++) begin
            set_req(5'(t), rand_cmd(), $urandom, $urandom);
            cyc();
        end
        set_req(5'd4, rand_cmd(), $urandom, $urandom);
        chk("fill_req_rdy_full", 64'(req_rdy), 64'(0));
        cyc(); cyc(); cyc();
        chk("fill_req_rdy_held", 64'(req_rdy), 64'(0));
        stub_lat = 0;
        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            acc = (req_rdy === 1'b1);
            cyc();
            if (acc) break;
        end
        req_vd = 1'b0;
        chk("fill_5th_accepted", 64'(acc), 64'(1));
        drain();
        chk("fill_rsp_count", 64'(rsp_log.size()), 64'(5));
        for (int t = 0; t < 5 && t < rsp_log.size(); t++) begin
            chk("fill_rsp_order", 64'(rsp_log[t]), 64'(t));
        end

        // Multi-cycle DIV
        rsp_log.delete();
        stub_lat = 32;
        set_req(5'd9, SCR1_IALU_CMD_DIV, 32'd100, 32'd7);
        cyc();
        req_vd = 1'b0;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            if (rsp_vd === 1'b1) break;
            if (ialu_vd === 1'b1) n++;
            cyc();
        end
        chk("div_issue_cycles", 64'(n), 64'(33));
        chk("div_rsp_vd", 64'(rsp_vd), 64'(1));
        chk("div_rsp_res", 64'(rsp_res), 64'(14));
        chk("div_rsp_tag", 64'(rsp_tag), 64'(9));
        cyc(); cyc(); cyc();
        chk("div_rsp_vd_off", 64'(rsp_vd), 64'(0));
        chk("div_one_rsp", 64'(rsp_log.size()), 64'(1));

        // Response backpressure with a second op queued
        stub_lat = 0;
        rsp_rdy  = 1'b0;
        set_req(5'd10, SCR1_IALU_CMD_XOR, $urandom, $urandom);
        cyc();
        b_op1 = $urandom;
        set_req(5'd11, SCR1_IALU_CMD_OR, b_op1, $urandom);
        cyc();
        req_vd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ialu_vd", 64'(ialu_vd), 64'(0));
            chk("bp_rsp_vd", 64'(rsp_vd), 64'(1));
            chk("bp_rsp_tag", 64'(rsp_tag), 64'(10));
            cyc();
        end
        rsp_rdy = 1'b1;
        cyc();
        chk("bp_second_issue", 64'(ialu_vd), 64'(1));
        chk("bp_second_op1", 64'(ialu_op1), 64'(b_op1));
        drain();

        // Flush during a DIV with two ops queued and ialu_rdy in the flush cycle
        rsp_log.delete();
        stub_lat = 1000;
        set_req(5'd20, SCR1_IALU_CMD_DIV, 32'd500, 32'd3);
        cyc();
        set_req(5'd21, SCR1_IALU_CMD_ADD, 32'd1, 32'd1);
        cyc();
        set_req(5'd22, SCR1_IALU_CMD_ADD, 32'd2, 32'd2);
        cyc();
        req_vd = 1'b0;
        cyc(); cyc(); cyc();
        stub_lat = 0;
        flush = 1'b1;
        set_req(5'd30, SCR1_IALU_CMD_ADD, 32'd3, 32'd3);
        cyc();
        flush  = 1'b0;
        req_vd = 1'b0;
        chk("flush_req_rdy", 64'(req_rdy), 64'(1));
        cyc();
        chk("flush_idle_ialu_vd", 64'(ialu_vd), 64'(0));
        chk("flush_idle_rsp_vd", 64'(rsp_vd), 64'(0));
        chk("flush_no_rsp", 64'(rsp_log.size()), 64'(0));
        set_req(5'd23, SCR1_IALU_CMD_ADD, 32'd40, 32'd2);
        cyc();
        req_vd = 1'b0;
        drain();
        chk("postflush_rsp_count", 64'(rsp_log.size()), 64'(1));
        if (rsp_log.size() != 0) chk("postflush_rsp_tag", 64'(rsp_log[0]), 64'(23));

        // Randomized traffic with flushes and spurious ialu_rdy outside issue
        rdy_noise = 1'b1;
        for (int i = 0; i < 400; i++) begin
            stub_lat = $urandom_range(0, 3);
            rsp_rdy  = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1) begin
                set_req(5'($urandom), rand_cmd(), $urandom, $urandom);
            end else begin
                req_vd = 1'b0;
            end
            cyc();
        end
        flush     = 1'b0;
        rdy_noise = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
